// File: rtl/edge_detector_bank.sv
// Bank of independent debounced edge detectors: 2-flop sync, persistence filter, pulse outputs.
// Optional sticky event flags and irq are built when EDGE_DETECTOR_BANK_STICKY_EN is defined.
module edge_detector_bank #(
  parameter int WIDTH         = 4,
  parameter int FILTER_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pos,
  output logic [WIDTH-1:0] neg,
  input  logic [WIDTH-1:0] clr_pos,
  input  logic [WIDTH-1:0] clr_neg,
  output logic [WIDTH-1:0] evt_pos,
  output logic [WIDTH-1:0] evt_neg,
  output logic             irq
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  // The count reached on the cycle before acceptance.
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] neg_q, neg_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    level_d = level_q;
    pos_d   = '0;
    neg_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == LAST) begin
          level_d[i] = s2_q[i];
          pos_d[i]   = s2_q[i];
          neg_d[i]   = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
      // NOTE: the counter array is per-channel control state, so it is reset like any other register; a partial count must not survive reset.
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep s1 -> s2 a true two-stage pipeline regardless of statement order.
      s1_q    <= in;
      s2_q    <= s1_q;
      level_q <= level_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign level = level_q;
  assign pos   = pos_q;
  assign neg   = neg_q;

`ifdef EDGE_DETECTOR_BANK_STICKY_EN
  logic [WIDTH-1:0] evt_pos_q, evt_pos_d;
  logic [WIDTH-1:0] evt_neg_q, evt_neg_d;

  // Set wins over clear when both land in the same cycle.
  always_comb begin
    evt_pos_d = (evt_pos_q & ~clr_pos) | pos_q;
    evt_neg_d = (evt_neg_q & ~clr_neg) | neg_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_pos_q <= '0;
      evt_neg_q <= '0;
    end else begin
      evt_pos_q <= evt_pos_d;
      evt_neg_q <= evt_neg_d;
    end
  end

  assign evt_pos = evt_pos_q;
  assign evt_neg = evt_neg_q;
  assign irq     = |{evt_pos_q, evt_neg_q};
`else
  logic unused_clr;
  assign unused_clr = ^{clr_pos, clr_neg};
  assign evt_pos    = '0;
  assign evt_neg    = '0;
  assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_edge_detector_bank.sv
// Self-checking bench for edge_detector_bank: window-based reference model plus directed literal checks.
// Define EDGE_DETECTOR_BANK_STICKY_EN for both files to exercise the sticky build.
module tb_edge_detector_bank;

  localparam int W = 4;
  localparam int F = 3;
`ifdef EDGE_DETECTOR_BANK_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] in, clr_pos, clr_neg;
  logic [W-1:0] level, pos, neg, evt_pos, evt_neg;
  logic irq;

  logic in1, clr1;
  logic level1, pos1, neg1, evt_pos1, evt_neg1, irq1;

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  edge_detector_bank #(.WIDTH(W), .FILTER_CYCLES(F)) u_dut (
    .clk(clk), .reset(reset), .in(in),
    .level(level), .pos(pos), .neg(neg),
    .clr_pos(clr_pos), .clr_neg(clr_neg),
    .evt_pos(evt_pos), .evt_neg(evt_neg), .irq(irq)
  );

  edge_detector_bank #(.WIDTH(1), .FILTER_CYCLES(1)) u_dut_f1 (
    .clk(clk), .reset(reset), .in(in1),
    .level(level1), .pos(pos1), .neg(neg1),
    .clr_pos(clr1), .clr_neg(clr1),
    .evt_pos(evt_pos1), .evt_neg(evt_neg1), .irq(irq1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: level flips once the synchronised value has disagreed with it for
  // each of the last F edges; the synchronised value trails the input by two edges.
  logic [W-1:0] m_sync [F];
  logic [W-1:0] m_in_prev;
  logic         m_reset_prev = 1'b0;
  logic [W-1:0] m_level, m_pos, m_neg, m_evt_pos, m_evt_neg;
  logic         m_valid = 1'b0;

  initial for (int j = 0; j < F; j++) m_sync[j] = '0;

  always @(posedge clk) begin
    logic [W-1:0] flip;
    logic [W-1:0] sync_now;
    if (reset) begin
      m_level = '0; m_pos = '0; m_neg = '0; m_evt_pos = '0; m_evt_neg = '0;
      m_valid = 1'b1;
    end else begin
      for (int i = 0; i < W; i++) begin
        flip[i] = 1'b1;
        for (int j = 0; j < F; j++)
          if (m_sync[j][i] == m_level[i]) flip[i] = 1'b0;
      end
      m_evt_pos = STICKY ? ((m_evt_pos & ~clr_pos) | m_pos) : '0;
      m_evt_neg = STICKY ? ((m_evt_neg & ~clr_neg) | m_neg) : '0;
      m_pos   = flip & ~m_level;
      m_neg   = flip & m_level;
      m_level = m_level ^ flip;
    end
    sync_now = (reset || m_reset_prev) ? '0 : m_in_prev;
    for (int j = F - 1; j > 0; j--) m_sync[j] = m_sync[j-1];
    m_sync[0]    = sync_now;
    m_in_prev    = in;
    m_reset_prev = reset;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("level",   level,   m_level);
      check("pos",     pos,     m_pos);
      check("neg",     neg,     m_neg);
      check("evt_pos", evt_pos, m_evt_pos);
      check("evt_neg", evt_neg, m_evt_neg);
      check("irq",     irq,     |{m_evt_pos, m_evt_neg});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [W-1:0] value;
    int           hold;
  } vec_t;

  vec_t vecs [9] = '{
    '{4'b1000, 3}, '{4'b0000, 3}, '{4'b1000, 3}, '{4'b0000, 2}, '{4'b1000, 4},
    '{4'b0101, 1}, '{4'b1010, 7}, '{4'b0110, 3}, '{4'b0000, 12}
  };

  initial begin
    reset = 1'b1; in = '0; clr_pos = '0; clr_neg = '0; in1 = 1'b0; clr1 = 1'b0;
    step(2);
    reset = 1'b0;
    check("rst_level", level, 0);
    check("rst_pulse", pos | neg, 0);
    check("rst_irq",   irq, 0);
    step(5);
    check("idle_level", level, 0);
    check("idle_irq",   irq, 0);

    // Single rise on channel 0: level follows 5 edges after the change.
    in[0] = 1'b1;
    step(4);
    check("rise_early", level[0], 0);
    step(1);
    check("rise_level", level[0], 1);
    check("rise_pos",   pos[0], 1);
    step(1);
    check("rise_pos_end", pos[0], 0);
    check("rise_evt",     evt_pos[0], STICKY);

    // Two-cycle glitch on channel 1 is filtered out.
    in[1] = 1'b1;
    step(2);
    in[1] = 1'b0;
    step(8);
    check("glitch_level", level[1], 0);
    check("glitch_evt",   evt_pos[1], 0);

    // All channels together.
    in[0] = 1'b0;
    step(6);
    in = 4'b1111;
    step(5);
    check("all_pos",   pos, 4'b1111);
    check("all_level", level, 4'b1111);
    step(1);
    check("all_pos_end", pos, 0);
    step(4);
    in = 4'b0000;
    step(5);
    check("all_neg", neg, 4'b1111);
    check("all_irq", irq, STICKY);
    step(1);
    check("all_neg_end", neg, 0);

    // Sticky clear: set beats clear, clear alone drops the flag.
    clr_pos = 4'b1111; clr_neg = 4'b1111;
    step(1);
    clr_pos = '0; clr_neg = '0;
    check("clr_all_irq", irq, 0);
    in[0] = 1'b1;
    step(6);
    check("evt_set", evt_pos[0], STICKY);
    in[0] = 1'b0;
    step(5);
    in[0] = 1'b1;
    step(5);
    check("second_pos", pos[0], 1);
    clr_pos = 4'b0001;
    step(1);
    clr_pos = '0;
    check("set_beats_clr", evt_pos[0], STICKY);
    clr_pos = 4'b0001; clr_neg = 4'b1111;
    step(1);
    clr_pos = '0; clr_neg = '0;
    check("clr_alone", evt_pos[0], 0);
    check("clr_irq",   irq, 0);

    // Reset while channel 2 is mid-count (counter at 2).
    in[2] = 1'b1;
    step(4);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check("mid_rst_level", level[2], 0);
    step(4);
    check("mid_rst_early", level[2], 0);
    check("mid_rst_nopos", pos[2], 0);
    step(1);
    check("mid_rst_pos",   pos[2], 1);
    check("mid_rst_level2", level[2], 1);
    step(1);
    check("mid_rst_pos_end", pos[2], 0);
    check("mid_rst_evt",     evt_pos[2], STICKY);

    // Directed vectors, including back-to-back transitions on channel 3.
    foreach (vecs[v]) begin
      in = vecs[v].value;
      step(vecs[v].hold);
    end

    // FILTER_CYCLES = 1 instance: no extra filtering beyond the synchroniser.
    in1 = 1'b1;
    step(2);
    check("f1_early", level1, 0);
    step(1);
    check("f1_rise", level1, 1);
    check("f1_pos",  pos1, 1);
    step(1);
    check("f1_pos_end", pos1, 0);
    check("f1_evt",     evt_pos1, STICKY);
    in1 = 1'b0;
    step(1);
    in1 = 1'b1;
    step(1);
    check("f1_hold", level1, 1);
    step(1);
    check("f1_neg",       neg1, 1);
    check("f1_neg_level", level1, 0);
    step(1);
    check("f1_pos2",    pos1, 1);
    check("f1_neg_end", neg1, 0);
    check("f1_level2",  level1, 1);

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/edge_detector_bank.md
EDGE_DETECTOR_BANK -- requirements
Module: edge_detector_bank

Interface
REQ-001 Parameter: WIDTH, default 4, number of independent input channels (1..32).
REQ-002 Parameter: FILTER_CYCLES, default 3, consecutive synchronised cycles a new level must persist before acceptance (1..255).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 Port: in  input  WIDTH  asynchronous raw channel levels.
REQ-006 Port: level  output  WIDTH  filtered, accepted level per channel (registered).
REQ-007 Port: pos  output  WIDTH  one-cycle pulse per channel on accepted 0->1 transition (registered).
REQ-008 Port: neg  output  WIDTH  one-cycle pulse per channel on accepted 1->0 transition (registered).
REQ-009 Port: clr_pos  input  WIDTH  write-1-to-clear for evt_pos bits (sticky build only).
REQ-010 Port: clr_neg  input  WIDTH  write-1-to-clear for evt_neg bits (sticky build only).
REQ-011 Port: evt_pos  output  WIDTH  sticky rising-edge flags.
REQ-012 Port: evt_neg  output  WIDTH  sticky falling-edge flags.
REQ-013 Port: irq  output  1  OR-reduction of all evt_pos and evt_neg bits.

Function
REQ-014 Each channel SHALL pass in[i] through a two-flop synchroniser (s1, s2); no logic between the flops.
REQ-015 Each channel SHALL hold a counter of width clog2(FILTER_CYCLES+1); counter cleared to 0 whenever s2 == level.
REQ-016 While s2 != level, counter SHALL increment each cycle; on the cycle where counter+1 == FILTER_CYCLES, level SHALL take s2 and counter SHALL clear.
REQ-017 Latency: an input change stable before clock edge k SHALL update level at edge k+1+FILTER_CYCLES.
REQ-018 A glitch of fewer than FILTER_CYCLES synchronised cycles SHALL NOT change level nor produce any pulse; counter restarts from 0 on the next deviation.
REQ-019 pos[i] SHALL be 1 for exactly the one cycle following the edge where level[i] changes 0->1; neg[i] likewise for 1->0; pos[i] and neg[i] never both 1.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on multiple channels each produce their own pulse in the same cycle.
REQ-021 Back-to-back accepted transitions on one channel SHALL be separated by at least FILTER_CYCLES cycles; each produces its own pulse.
REQ-022 FILTER_CYCLES == 1 SHALL accept a level one cycle after it appears at s2 (no extra filtering).

Reset
REQ-023 On reset: s1, s2, level, counters, pos, neg, evt_pos, evt_neg SHALL all be 0; irq SHALL be 0.
REQ-024 Reset mid-filter SHALL discard the partial count; no pulse is produced for the interrupted transition.
REQ-025 If in[i] is 1 across reset release at edge r, level[i] SHALL rise with a pos[i] pulse at edge r+2+FILTER_CYCLES.

Configuration
REQ-026 Macro EDGE_DETECTOR_BANK_STICKY_EN defined: evt_pos[i] set when pos[i] is 1, evt_neg[i] set when neg[i] is 1; cleared the cycle after clr bit is 1; simultaneous set and clear SHALL leave the flag set.
REQ-027 Macro undefined: evt_pos, evt_neg and irq SHALL be constant 0; clr_pos and clr_neg ignored; no sticky registers synthesised.

Verification
REQ-028 WIDTH=4, F=3: reset 2 cycles, in=4'b0000 -> level=0, pos=neg=0, irq=0 throughout.
REQ-029 in[0] 0->1 before edge 10, held -> level[0]=1 at edge 14, pos[0]=1 for cycle 14-15 only, evt_pos[0]=1 from edge 15 (sticky build).
REQ-030 in[1] high for 2 cycles then low (glitch) -> level[1] stays 0, no pos/neg, evt_pos[1]=0.
REQ-031 in=4'b1111 at one edge, then in=4'b0000 10 cycles later -> pos=4'b1111 in a single cycle, later neg=4'b1111 in a single cycle, irq=1.
REQ-032 With evt_pos[0]=1, assert clr_pos=4'b0001 for one cycle coinciding with a new pos[0] -> evt_pos[0] remains 1; clr alone next time -> evt_pos[0]=0, irq=0 if no other flag.
REQ-033 Reset asserted during count (counter=2) with in[2]=1 held -> no pulse during/after reset until edge r+2+3; then pos[2]=1 once; non-sticky build: evt/irq stay 0.
